// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: locks to an incoming hsync/vsync/pixel stream paced by a one-clk pixel
// strobe, recovers the column/row of each sampled pixel and emits frame-buffer writes with a
// linear address (row * H_ACTIVE + col) for the visible area. Sync timing violations pulse
// sync_error and drop back to searching for a fresh hsync edge.
//
// Ports:
//   clk, n_rst        system clock, asynchronous active-low reset
//   pixel_en          one-clk strobe; every other input is sampled only when it is high
//   hsync_n, vsync_n  active-low syncs
//   pixel_in          pixel data
//   wr_en             one-clk write strobe, with wr_addr / wr_data
//   col_out, row_out  recovered position of the last sampled pixel
//   locked            high while fully locked
//   frame_done        pulses with the write to the last visible address
//   sync_error        pulses on a timing violation
module vga_timing_receiver #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              pixel_en,
  input  logic              hsync_n,
  input  logic              vsync_n,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              wr_en,
  output logic [19:0]       wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [9:0]        col_out,
  output logic [9:0]        row_out,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_error
);

  localparam logic [19:0] ADDR_LAST = 20'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [9:0]  COL_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  ROW_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  COL_SYNC  = 10'(H_SYNC_START);
  localparam logic [9:0]  ROW_SYNC  = 10'(V_SYNC_START);
  localparam logic [9:0]  COL_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  ROW_ACT   = 10'(V_ACTIVE);

  typedef enum logic [1:0] {StSearch, StHlock, StLocked} state_e;

  state_e      state_q;
  logic        prev_h_q;
  logic        prev_v_q;
  logic [19:0] addr_q;     // address the next write will use

  logic       h_edge;
  logic       v_edge;
  logic [9:0] next_col;
  logic [9:0] next_row;
  logic       hlock_err;
  logic       locked_err;
  logic       in_active;

  always_comb begin
    h_edge   = prev_h_q & ~hsync_n;
    v_edge   = prev_v_q & ~vsync_n;
    next_col = (col_out == COL_LAST) ? 10'd0 : col_out + 10'd1;
    next_row = row_out;
    if (next_col == 10'd0) begin
      next_row = (row_out == ROW_LAST) ? 10'd0 : row_out + 10'd1;
    end
    // Only the column is tracked before full lock, so only hsync placement can be judged.
    hlock_err  = (v_edge && (next_col != 10'd0)) || (h_edge != (next_col == COL_SYNC));
    // Both directions: a misplaced sync and a missing sync are violations.
    locked_err = (h_edge != (next_col == COL_SYNC)) ||
                 (v_edge != ((next_row == ROW_SYNC) && (next_col == 10'd0)));
    in_active  = (next_col < COL_ACT) && (next_row < ROW_ACT);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StSearch;
      prev_h_q   <= 1'b1;
      prev_v_q   <= 1'b1;
      addr_q     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      col_out    <= '0;
      row_out    <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      sync_error <= 1'b0;
      if (pixel_en) begin
        prev_h_q <= hsync_n;
        prev_v_q <= vsync_n;
        unique case (state_q)
          StSearch: begin
            // A vsync edge here is ignored; hsync wins when both arrive together.
            if (h_edge) begin
              col_out <= COL_SYNC;
              row_out <= '0;
              state_q <= StHlock;
            end
          end
          StHlock: begin
            if (hlock_err) begin
              sync_error <= 1'b1;
              state_q    <= StSearch;
            end else begin
              col_out <= next_col;
              if (v_edge) begin
                row_out <= ROW_SYNC;
                wr_addr <= '0;
                addr_q  <= '0;
                locked  <= 1'b1;
                state_q <= StLocked;
              end
            end
          end
          StLocked: begin
            if (locked_err) begin
              sync_error <= 1'b1;
              locked     <= 1'b0;
              state_q    <= StSearch;
            end else begin
              col_out <= next_col;
              row_out <= next_row;
              if (v_edge) begin
                wr_addr <= '0;
                addr_q  <= '0;
              end
              // v_edge lands outside the visible rows, so it never coincides with a write.
              if (in_active) begin
                wr_en      <= 1'b1;
                wr_data    <= pixel_in;
                wr_addr    <= addr_q;
                frame_done <= (addr_q == ADDR_LAST);
                addr_q     <= (addr_q == ADDR_LAST) ? 20'd0 : addr_q + 20'd1;
              end
            end
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Scoreboard bench for vga_timing_receiver on a shrunken raster (16x11 total, 8x6 visible).
// The stimulus side pushes the expected per-pixel status and expected writes into queues;
// a separate monitor pops and compares whenever the DUT samples a pixel or strobes wr_en.
module tb_vga_timing_receiver;

  localparam int HA    = 8;
  localparam int HSS   = 10;
  localparam int HT    = 16;
  localparam int HW    = 3;   // hsync low width in pixels
  localparam int VA    = 6;
  localparam int VSS   = 8;
  localparam int VT    = 11;
  localparam int VW    = 2;   // vsync low width in lines
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        pixel_en = 1'b0;
  logic        hsync_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic [7:0]  pixel_in = 8'h00;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic [9:0]  col_out;
  logic [9:0]  row_out;
  logic        locked;
  logic        frame_done;
  logic        sync_error;

  vga_timing_receiver #(
    .H_ACTIVE    (HA),
    .H_SYNC_START(HSS),
    .H_TOTAL     (HT),
    .V_ACTIVE    (VA),
    .V_SYNC_START(VSS),
    .V_TOTAL     (VT),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pixel_en  (pixel_en),
    .hsync_n   (hsync_n),
    .vsync_n   (vsync_n),
    .pixel_in  (pixel_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .col_out   (col_out),
    .row_out   (row_out),
    .locked    (locked),
    .frame_done(frame_done),
    .sync_error(sync_error)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit err;
    bit lk;
    bit pchk;
    int col;
    int row;
  } pos_t;

  typedef struct {
    int         addr;
    logic [7:0] data;
    bit         fd;
  } wr_t;

  pos_t pq[$];
  wr_t  wq[$];

  int n_vec = 0;
  int n_miss = 0;
  int wr_count = 0;
  int fd_count = 0;
  int err_count = 0;

  // Stimulus-side knowledge of the stream.
  int cur_c = 0;
  int cur_r = 0;
  int ph = 0;        // 0 searching, 1 line-locked, 2 locked
  int gap_mode = 0;  // 0 fixed spacing of 4, 1 irregular 1..7
  int gidx = 0;
  bit last_hs = 1'b1;
  bit last_vs = 1'b1;
  bit sampled;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    n_miss++;
    $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int next_gap();
    if (gap_mode == 0) return 4;
    gidx++;
    return 1 + (gidx * 5 + 3) % 7;
  endfunction

  // Monitor: pops the pixel queue after every sampled pixel, the write queue on every wr_en.
  initial begin
    forever begin
      @(posedge clk);
      sampled = pixel_en && n_rst;
      @(negedge clk);
      if (n_rst) begin
        if (wr_en) begin
          wr_count++;
          if (frame_done) fd_count++;
          if (wq.size() == 0) begin
            fail_now("unexpected_wr_addr", 32'(wr_addr), 32'hffff_ffff);
          end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(w.addr));
            chk("wr_data", 32'(wr_data), 32'(w.data));
            chk("frame_done", 32'(frame_done), 32'(w.fd));
          end
        end else begin
          chk("frame_done_without_wr", 32'(frame_done), 32'd0);
        end
        if (sync_error) err_count++;
        if (sampled) begin
          if (pq.size() == 0) begin
            fail_now("pixel_queue_empty", 32'(col_out), 32'hffff_ffff);
          end else begin
            pos_t p;
            p = pq.pop_front();
            chk("sync_error", 32'(sync_error), 32'(p.err));
            chk("locked", 32'(locked), 32'(p.lk));
            if (p.pchk) begin
              chk("col_out", 32'(col_out), 32'(p.col));
              chk("row_out", 32'(row_out), 32'(p.row));
            end
          end
        end else begin
          chk("wr_en_idle", 32'(wr_en), 32'd0);
          chk("sync_error_idle", 32'(sync_error), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  // Send the pixel at the current true position with the given syncs and expectations.
  task automatic send(input bit hs, input bit vs, input bit err, input bit lk,
                      input bit pchk, input int ec, input int er);
    pos_t it;
    int   g;
    it.err  = err;
    it.lk   = lk;
    it.pchk = pchk;
    it.col  = ec;
    it.row  = er;
    pq.push_back(it);
    @(negedge clk);
    pixel_en = 1'b1;
    hsync_n  = hs;
    vsync_n  = vs;
    pixel_in = 8'(cur_c ^ cur_r);
    last_hs  = hs;
    last_vs  = vs;
    cur_c++;
    if (cur_c == HT) begin
      cur_c = 0;
      cur_r = (cur_r + 1) % VT;
    end
    g = next_gap();
    for (int i = 1; i < g; i++) begin
      @(negedge clk);
      pixel_en = 1'b0;
    end
  endtask

  // One pixel of a clean stream; expectations follow lock acquisition on nominal timing.
  task automatic step_nominal();
    bit  hs, vs, he, ve, pchk, was_locked;
    int  ec, er;
    wr_t w;
    hs = !(cur_c >= HSS && cur_c < HSS + HW);
    vs = !(cur_r >= VSS && cur_r < VSS + VW);
    he = last_hs && !hs;
    ve = last_vs && !vs;
    was_locked = (ph == 2);
    pchk = 1'b0;
    ec = 0;
    er = 0;
    case (ph)
      0: if (he) begin
        ph = 1;
        pchk = 1'b1;
        ec = HSS;
      end
      1: begin
        pchk = 1'b1;
        ec = cur_c;
        if (ve && cur_c == 0) begin
          ph = 2;
          er = cur_r;
        end
      end
      default: begin
        pchk = 1'b1;
        ec = cur_c;
        er = cur_r;
      end
    endcase
    if (was_locked && cur_c < HA && cur_r < VA) begin
      w.addr = cur_r * HA + cur_c;
      w.data = 8'(cur_c ^ cur_r);
      w.fd   = (w.addr == HA * VA - 1);
      wq.push_back(w);
    end
    send(hs, vs, 1'b0, ph == 2, pchk, ec, er);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step_nominal();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_col_out"}, 32'(col_out), 32'd0);
    chk({tag, "_row_out"}, 32'(row_out), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_sync_error"}, 32'(sync_error), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int wrs, input int fds, input int errs);
    repeat (2) @(negedge clk);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(wrs));
    chk({tag, "_frame_done_count"}, 32'(fd_count), 32'(fds));
    chk({tag, "_sync_error_count"}, 32'(err_count), 32'(errs));
  endtask

  initial begin
    // Reset.
    #1 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    n_rst = 1'b1;

    // Two clean frames: lock at row VSS of frame 1, full frame of writes in frame 2.
    run_n(2 * FRAME);
    check_counts("clean", 48, 1, 0);
    chk("clean_locked", 32'(locked), 32'd1);

    // Frame 3: hsync edge of row 2 arrives two pixels late.
    run_n(2 * HT + HSS);                          // 24 writes, up to (HSS-1, 2)
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, HSS - 1, 2);  // missing edge at HSS
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, HSS - 1, 2);
    send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, HSS, 0);      // late edge relocks the line counter
    for (int c = HSS + 3; c < HT; c++) begin
      send((c < HSS + 2 + HW) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, c - 2, 0);
    end
    for (int c = 0; c < HSS; c++) begin
      send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, (c + HT - 2) % HT, 0);
    end
    send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HSS - 3, 0);  // nominal edge now misplaced
    ph = 0;
    run_n(FRAME - (3 * HT + HSS + 1) + FRAME);     // relock in frame 3, full frame 4
    check_counts("hshift", 120, 2, 2);

    // Frame 5: vsync pulse omitted, stray vsync edge while searching.
    run_n(VSS * HT);                               // 48 writes
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, HT - 1, VSS - 1);
    for (int c = 1; c < HSS; c++) begin
      send(1'b1, (c == 3 || c == 4) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b1, HT - 1, VSS - 1);
    end
    ph = 0;
    // hsync and the late vsync tail fall together at (HSS, VSS): hsync wins.
    run_n(FRAME - (VSS * HT + HSS) + FRAME + 3 * HT + 6);  // lock frame 6, 30 writes frame 7
    check_counts("vmiss", 198, 3, 3);
    chk("vmiss_locked", 32'(locked), 32'd1);

    // Asynchronous reset mid-frame, then irregular pixel spacing while reacquiring.
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    last_hs = 1'b1;
    last_vs = 1'b1;
    ph = 0;
    gap_mode = 1;
    run_n(FRAME - (3 * HT + 6) + FRAME);          // lock in frame 7, frame 8 from addr 0
    @(negedge clk);
    pixel_en = 1'b0;
    check_counts("rerst", 246, 4, 3);
    chk("rerst_locked", 32'(locked), 32'd1);
    chk("pixel_queue_drained", 32'(pq.size()), 32'd0);
    chk("write_queue_drained", 32'(wq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
